jtag_dr_mailbox_ctrl: RTL and testbench

//   Sequences the USER data register behind the BSCANE2 primitive. Deserialises host
//   DR frames into single-cycle command pulses for user logic. Serialises one

---
 rtl/jtag_dr_mailbox_ctrl.sv | 138 +++++++++++++
 tb/tb_jtag_dr_mailbox_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dr_mailbox_ctrl.sv
// USER data-register sequencer behind BSCANE2: turns host DR scans into
// command pulses and returns one buffered response word per scan (tck domain).
module jtag_dr_mailbox_ctrl #(
   parameter int DATA_W = 8
) (
   input  logic              tck,
   input  logic              test_logic_reset,
   input  logic              tdi,
   output logic              tdo,
   input  logic              ir_is_user,
   input  logic              capture_dr,
   input  logic              shift_dr,
   input  logic              update_dr,
   output logic [DATA_W-1:0] cmd_data,
   output logic              cmd_valid,
   input  logic [DATA_W-1:0] rsp_data,
   input  logic              rsp_valid,
   output logic              rsp_ready,
   output logic              frame_err
);

   localparam int DR_W = DATA_W + 2;
   localparam int CW   = $clog2(DR_W + 2);

   typedef enum logic [1:0] {
      IDLE,
      CAP,
      SHIFT
   } state_t;

   state_t              state;
   logic [DR_W-1:0]     shreg;
   logic [CW-1:0]       bitcnt;
   logic                rsp_full;
   logic                cap_pend;
   logic [DATA_W-1:0]   rsp_buf;

   logic [DR_W-1:0]     cap_word;
   logic                push;
   logic                upd_frame;
   logic                frame_ok;
   logic                frame_bad;
   logic                frame_wr;
   logic                frame_ack;
   logic                pop;

   assign tdo       = shreg[0];
   assign rsp_ready = ~rsp_full;
   assign push      = rsp_valid & ~rsp_full;

   // Capture snapshot: response (zero when empty), full flag, sticky error
   assign cap_word  = {frame_err, rsp_full,
                       rsp_full ? rsp_buf : {DATA_W{1'b0}}};

   // Update seen while a shifted frame is open decides the frame's fate
   assign upd_frame = ir_is_user & ~capture_dr & ~shift_dr
                      & update_dr & (state == SHIFT);
   assign frame_ok  = upd_frame & (bitcnt == CW'(DR_W));
   assign frame_bad = upd_frame & (bitcnt != CW'(DR_W))
                      & (bitcnt != '0);
   assign frame_wr  = shreg[DR_W-2];
   assign frame_ack = shreg[DR_W-1];

   // Ack only pops the entry this scan actually showed to the host
   assign pop       = frame_ok & frame_ack & cap_pend;

   // Scan sequencer: capture/shift/update tracking and the DR shifter
   always_ff @(posedge tck) begin
      if (test_logic_reset) begin
         state    <= IDLE;
         shreg    <= '0;
         bitcnt   <= '0;
         cap_pend <= 1'b0;
      end else if (!ir_is_user) begin
         state    <= IDLE;
      end else if (capture_dr) begin
         state    <= CAP;
         shreg    <= cap_word;
         cap_pend <= rsp_full;
         bitcnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               state <= IDLE;
            end
            CAP, SHIFT: begin
               if (shift_dr) begin
                  state <= SHIFT;
                  shreg <= {tdi, shreg[DR_W-1:1]};
                  if (bitcnt != CW'(DR_W + 1))
                     bitcnt <= bitcnt + CW'(1);
               end else if (update_dr) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Command pulse: one cycle after a valid write frame's update
   always_ff @(posedge tck) begin
      if (test_logic_reset) begin
         cmd_valid <= 1'b0;
         cmd_data  <= '0;
      end else begin
         cmd_valid <= frame_ok & frame_wr;
         if (frame_ok && frame_wr)
            cmd_data <= shreg[DATA_W-1:0];
      end
   end

   // Sticky framing error: short/long scans set, acked valid frame clears
   always_ff @(posedge tck) begin
      if (test_logic_reset)
         frame_err <= 1'b0;
      else if (frame_bad)
         frame_err <= 1'b1;
      else if (frame_ok && frame_ack)
         frame_err <= 1'b0;
   end

   // Single-entry response buffer
   always_ff @(posedge tck) begin
      if (test_logic_reset) begin
         rsp_full <= 1'b0;
         rsp_buf  <= '0;
      end else if (pop) begin
         rsp_full <= 1'b0;
      end else if (push) begin
         rsp_full <= 1'b1;
         rsp_buf  <= rsp_data;
      end
   end

endmodule

// File: tb/tb_jtag_dr_mailbox_ctrl.sv
// Directed bench for jtag_dr_mailbox_ctrl: scan-level model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_jtag_dr_mailbox_ctrl;

   localparam int DW  = 8;
   localparam int DRW = DW + 2;

   logic          clk = 1'b0;
   logic          test_logic_reset = 1'b1;
   logic          tdi = 1'b0;
   logic          tdo;
   logic          ir_is_user = 1'b1;
   logic          capture_dr = 1'b0;
   logic          shift_dr = 1'b0;
   logic          update_dr = 1'b0;
   logic [DW-1:0] cmd_data;
   logic          cmd_valid;
   logic [DW-1:0] rsp_data = '0;
   logic          rsp_valid = 1'b0;
   logic          rsp_ready;
   logic          frame_err;

   always #5 clk = ~clk;

   jtag_dr_mailbox_ctrl #(.DATA_W(DW)) dut (
      .tck              (clk),
      .test_logic_reset (test_logic_reset),
      .tdi              (tdi),
      .tdo              (tdo),
      .ir_is_user       (ir_is_user),
      .capture_dr       (capture_dr),
      .shift_dr         (shift_dr),
      .update_dr        (update_dr),
      .cmd_data         (cmd_data),
      .cmd_valid        (cmd_valid),
      .rsp_data         (rsp_data),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .frame_err        (frame_err)
   );

   int checks = 0;
   int passes = 0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
   endtask

   // Scan-level model: a scan is "captured word + list of tdi bits"
   logic          m_full, m_err, m_scan, m_pend, m_cv, m_push;
   logic [DW-1:0] m_buf, m_cd;
   logic [DRW-1:0] m_cap, m_fr;
   logic          m_bits[$];
   int            m_n;

   always @(posedge clk) begin
      if (test_logic_reset) begin
         m_full = 0; m_buf = '0; m_err = 0; m_scan = 0; m_pend = 0;
         m_cap = '0; m_bits.delete(); m_n = 0; m_cv = 0; m_cd = '0;
      end else begin
         m_push = rsp_valid && !m_full;
         m_cv = 0;
         if (!ir_is_user) begin
            m_scan = 0;
         end else if (capture_dr) begin
            m_cap = {m_err, m_full, m_full ? m_buf : 8'h00};
            m_pend = m_full; m_scan = 1; m_bits.delete(); m_n = 0;
         end else if (m_scan && shift_dr) begin
            m_bits.push_back(tdi); m_n++;
         end else if (m_scan && update_dr) begin
            m_scan = 0;
            if (m_n == DRW) begin
               for (int i = 0; i < DRW; i++) m_fr[i] = m_bits[i];
               if (m_fr[DW]) begin m_cv = 1; m_cd = m_fr[DW-1:0]; end
               if (m_fr[DW+1]) begin
                  m_err = 0;
                  if (m_pend) m_full = 0;
               end
            end else if (m_n != 0) begin
               m_err = 1;
            end
         end
         if (m_push) begin m_full = 1; m_buf = rsp_data; end
      end
   end

   // Per-cycle comparison against the model
   always @(posedge clk) begin
      logic e_tdo;
      #1;
      e_tdo = (m_n < DRW) ? m_cap[m_n] : m_bits[m_n - DRW];
      chk("cyc_tdo", tdo, e_tdo);
      chk("cyc_rsp_ready", rsp_ready, !m_full);
      chk("cyc_frame_err", frame_err, m_err);
      chk("cyc_cmd_valid", cmd_valid, m_cv);
      if (m_cv) chk("cyc_cmd_data", cmd_data, m_cd);
   end

   task automatic scan(input logic [DRW-1:0] w, input int nb,
                       input int pause_at, input int drop_at,
                       input logic push, input logic [DW-1:0] pd,
                       output logic [DRW-1:0] capd,
                       output logic cv, output logic [DW-1:0] cd);
      capd = '0;
      @(negedge clk);
      capture_dr = 1; shift_dr = 0; update_dr = 0;
      rsp_valid = push; rsp_data = pd;
      for (int i = 0; i < nb; i++) begin
         if (pause_at > 0 && i == pause_at) begin
            repeat (2) begin
               @(negedge clk);
               capture_dr = 0; shift_dr = 0; rsp_valid = 0;
            end
         end
         if (drop_at > 0 && i == drop_at) begin
            @(negedge clk);
            capture_dr = 0; shift_dr = 0; rsp_valid = 0; ir_is_user = 0;
         end
         @(negedge clk);
         if (i < DRW) capd[i] = tdo;
         capture_dr = 0; rsp_valid = 0; ir_is_user = 1;
         shift_dr = 1; tdi = w[i];
      end
      @(negedge clk);
      capture_dr = 0; rsp_valid = 0; shift_dr = 0; update_dr = 1;
      @(negedge clk);
      update_dr = 0;
      cv = cmd_valid; cd = cmd_data;
   endtask

   logic [DRW-1:0] capd;
   logic           cv;
   logic [DW-1:0]  cd;

   initial begin
      repeat (2) @(negedge clk);
      test_logic_reset = 0;
      chk("rst_tdo", tdo, 0);
      chk("rst_rsp_ready", rsp_ready, 1);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_frame_err", frame_err, 0);

      // 1: write frame 0xA5
      scan(10'h1A5, 10, 0, 0, 0, 8'h00, capd, cv, cd);
      chk("t1_capture", capd, 10'h000);
      chk("t1_cmd_valid", cv, 1);
      chk("t1_cmd_data", cd, 8'hA5);
      @(negedge clk);
      chk("t1_pulse_len", cmd_valid, 0);

      // 2: response round trip
      rsp_valid = 1; rsp_data = 8'h3C;
      @(negedge clk);
      rsp_valid = 0;
      chk("t2_full", rsp_ready, 0);
      scan(10'h200, 10, 0, 0, 0, 8'h00, capd, cv, cd);
      chk("t2_capture", capd, 10'h13C);
      chk("t2_no_cmd", cv, 0);
      chk("t2_popped", rsp_ready, 1);
      scan(10'h000, 10, 0, 0, 0, 8'h00, capd, cv, cd);
      chk("t2_empty_capture", capd, 10'h000);

      // 3: short frame
      scan(10'h1FF, 7, 0, 0, 0, 8'h00, capd, cv, cd);
      chk("t3_no_cmd", cv, 0);
      chk("t3_err_set", frame_err, 1);
      scan(10'h200, 10, 0, 0, 0, 8'h00, capd, cv, cd);
      chk("t3_err_capture", capd, 10'h200);
      chk("t3_err_clear", frame_err, 0);

      // 4: push coincident with capture must survive the ack
      scan(10'h200, 10, 0, 0, 1, 8'h5A, capd, cv, cd);
      chk("t4_capture", capd, 10'h000);
      chk("t4_still_full", rsp_ready, 0);
      scan(10'h200, 10, 0, 0, 0, 8'h00, capd, cv, cd);
      chk("t4_second_capture", capd, 10'h15A);
      chk("t4_popped", rsp_ready, 1);

      // 5: pause mid-scan
      scan(10'h1C3, 10, 4, 0, 0, 8'h00, capd, cv, cd);
      chk("t5_cmd_valid", cv, 1);
      chk("t5_cmd_data", cd, 8'hC3);
      chk("t5_no_err", frame_err, 0);

      // 6a: IR leaves USER mid-shift
      scan(10'h1FF, 10, 0, 5, 0, 8'h00, capd, cv, cd);
      chk("t6_no_cmd", cv, 0);
      chk("t6_no_err", frame_err, 0);

      // 6b: reset mid-frame drops the buffered response
      @(negedge clk); rsp_valid = 1; rsp_data = 8'h77;
      @(negedge clk); rsp_valid = 0; capture_dr = 1;
      @(negedge clk); capture_dr = 0; shift_dr = 1; tdi = 1;
      repeat (3) @(negedge clk);
      shift_dr = 0; test_logic_reset = 1;
      @(negedge clk);
      test_logic_reset = 0;
      chk("t6_rst_tdo", tdo, 0);
      chk("t6_rst_rsp_ready", rsp_ready, 1);
      chk("t6_rst_cmd_valid", cmd_valid, 0);
      chk("t6_rst_frame_err", frame_err, 0);
      scan(10'h000, 10, 0, 0, 0, 8'h00, capd, cv, cd);
      chk("t6_dropped", capd, 10'h000);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
